// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a floor of 1 keeps the vector legal for tiny widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_ctrl_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl_full_adder_1b.sv
// Single-bit full adder shared across all bit positions of the serial add.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures operands on start, adds LSB first one bit per
// clock through a single full adder, then publishes {cout,sum} with a done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             fa_s, fa_co;

  full_adder_1b u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      res_reg   <= res_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    res_next   = res_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_sh_next  = bus.a;
          b_sh_next  = bus.b;
          carry_next = bus.cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        res_next   = {fa_s, res_reg[WIDTH-1:1]};
        carry_next = fa_co;
        // The final bit lands in the same edge that publishes the result.
        if (cnt_reg == LAST_CNT) begin
          sum_next   = {fa_s, res_reg[WIDTH-1:1]};
          cout_next  = fa_co;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed table, multi-cycle corner sequences and a random sweep at WIDTH 8 and 3.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(3)) bus3 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Drives one addition on the 8-bit instance; operands are scrambled right
  // after acceptance, and optionally a second start is pulsed mid-run.
  task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input bit repulse, output logic [7:0] s, output logic co,
                         output int lat, output int busy_n, output int hold_bad);
    logic [7:0] prev_s;
    logic       prev_c;
    @(negedge clk);
    prev_s = bus8.sum;
    prev_c = bus8.cout;
    bus8.a = av; bus8.b = bv; bus8.cin = ci; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = ~av; bus8.b = ~bv; bus8.cin = ~ci;
    lat = 1; busy_n = 0; hold_bad = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      if (bus8.busy === 1'b1) busy_n++;
      if (bus8.sum !== prev_s || bus8.cout !== prev_c) hold_bad++;
      if (repulse && lat == 3) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
      end else if (repulse && lat == 4) begin
        bus8.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  task automatic do_add3(input logic [2:0] av, input logic [2:0] bv, input logic ci,
                         output logic [2:0] s, output logic co, output int lat);
    @(negedge clk);
    bus3.a = av; bus3.b = bv; bus3.cin = ci; bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    bus3.a = ~av; bus3.b = ~bv; bus3.cin = ~ci;
    lat = 1;
    while (bus3.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s  = bus3.sum;
    co = bus3.cout;
  endtask

  initial begin
    logic [7:0] s8;
    logic [2:0] s3;
    logic       co;
    int         lat, busy_n, hold_bad, cyc, last, ndone, done_seen;
    logic [7:0] ra, rb;
    logic [2:0] ta, tb;
    logic       rc;
    logic [8:0] ref9;
    logic [3:0] ref4;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_sum",  32'(bus8.sum),  32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_sum3", 32'(bus3.sum),  32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_add8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s8, co, lat, busy_n, hold_bad);
      $display("vec%0d a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, s8, co, lat, busy_n);
      check($sformatf("vec%0d_sum", i),  32'(s8), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
      check($sformatf("vec%0d_hold", i), 32'(hold_bad), 32'd0);
    end

    // Re-pulsed start with new operands mid-run is ignored
    do_add8(8'h12, 8'h34, 1'b0, 1'b1, s8, co, lat, busy_n, hold_bad);
    $display("repulse a=12 b=34 cin=0 -> sum=%h cout=%b lat=%0d", s8, co, lat);
    check("repulse_sum", 32'(s8), 32'h46);
    check("repulse_cout", 32'(co), 32'd0);
    check("repulse_latency", 32'(lat), 32'd9);
    check("repulse_hold", 32'(hold_bad), 32'd0);
    @(negedge clk);
    check("repulse_no_restart", 32'(bus8.busy), 32'd0);

    // Reset during the 4th RUN cycle
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("midrun_reset -> busy=%b done=%b sum=%h cout=%b", bus8.busy, bus8.done, bus8.sum, bus8.cout);
    check("midrun_busy", 32'(bus8.busy), 32'd0);
    check("midrun_done", 32'(bus8.done), 32'd0);
    check("midrun_sum",  32'(bus8.sum),  32'd0);
    check("midrun_cout", 32'(bus8.cout), 32'd0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) done_seen++;
    end
    check("midrun_no_done", 32'(done_seen), 32'd0);

    // rst and start together: rst wins
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    $display("rst_with_start -> busy=%b", bus8.busy);
    check("rst_start_busy_after", 32'(bus8.busy), 32'd0);

    // start held high: back-to-back additions
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
    cyc = 0; ndone = 0; last = -1;
    while (ndone < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus8.done === 1'b1) begin
        $display("b2b done at cycle %0d sum=%h cout=%b", cyc, bus8.sum, bus8.cout);
        if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'd10);
        check("b2b_sum", 32'(bus8.sum), 32'h03);
        last = cyc;
        ndone++;
      end
    end
    bus8.start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    repeat (2) @(negedge clk);

    // Random sweep, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_add8(ra, rb, rc, 1'b0, s8, co, lat, busy_n, hold_bad);
      $display("rnd8 a=%h b=%h cin=%b -> %h%h", ra, rb, rc, co, s8);
      check("rnd8_result", 32'({co, s8}), 32'(ref9));
    end

    // Random sweep, WIDTH=3
    for (int i = 0; i < 1000; i++) begin
      ta = 3'($urandom); tb = 3'($urandom); rc = 1'($urandom);
      ref4 = {1'b0, ta} + {1'b0, tb} + {3'd0, rc};
      do_add3(ta, tb, rc, s3, co, lat);
      $display("rnd3 a=%h b=%h cin=%b -> %h%h lat=%0d", ta, tb, rc, co, s3, lat);
      check("rnd3_result", 32'({co, s3}), 32'(ref4));
      if (i < 4) check("rnd3_latency", 32'(lat), 32'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
